// File: rtl/stall_ctrl.sv
// stall_ctrl: central stall controller for the five-stage MIPS core.
// Merges the ID load-use request with the multi-cycle divider handshake
// into the 6-bit stall bus (bit 0 PC .. bit 5 WB). It also keeps a sticky
// divide-timeout error flag and a saturating stall-cycle counter.
module stall_ctrl #(
    parameter int DIV_TIMEOUT = 40,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_for_load,
    input  logic             div_req,
    input  logic             div_ready,
    input  logic             perf_clr,
    output logic [5:0]       stall,
    output logic             div_start,
    output logic             div_abort,
    output logic             div_err,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // Stall patterns: a divide freezes PC..EX; a load-use freezes PC..ID and
    // lets EX take a bubble.
    localparam logic [5:0] STALL_DIV  = 6'b001111;
    localparam logic [5:0] STALL_LOAD = 6'b000111;
    localparam logic [7:0] WCNT_LAST  = 8'(DIV_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       stall_c;
    logic             start_c, abort_c;

    // Next-state and zero-latency outputs; the older divide in EX wins over
    // the younger load-use request in ID.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        stall_c = 6'b000000;
        start_c = 1'b0;
        abort_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (div_req) begin
                    stall_c = STALL_DIV;
                    start_c = 1'b1;
                    state_d = BUSY;
                    wcnt_d  = 8'd0;
                end else if (stallreq_for_load) begin
                    stall_c = STALL_LOAD;
                end
            end
            BUSY: begin
                // Ready is checked before timeout so a late result is never
                // thrown away.
                if (div_ready) begin
                    state_d = IDLE;
                end else if (wcnt_q == WCNT_LAST) begin
                    abort_c = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall_c = STALL_DIV;
                    wcnt_d  = wcnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset masks the combinational outputs in the reset cycle itself.
        if (rst) begin
            stall_c = 6'b000000;
            start_c = 1'b0;
            abort_c = 1'b0;
        end
    end

    // Stall-cycle counter: clear beats increment, saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (perf_clr)
            cnt_d = '0;
        else if (stall_c != 6'b000000 && cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= 8'd0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall        = stall_c;
    assign div_start    = start_c;
    assign div_abort    = abort_c;
    assign div_err      = err_q;
    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl. Instance A uses the default parameters,
// instance B uses DIV_TIMEOUT=4 / CNT_W=4 for timeout and saturation cases.
// Both share the same stimulus; each step checks the relevant instance.
module tb_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst, load, div_req, div_ready, perf_clr;
    logic [5:0]  a_stall, b_stall;
    logic        a_start, a_abort, a_err, b_start, b_abort, b_err;
    logic [31:0] a_cnt;
    logic [3:0]  b_cnt;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    stall_ctrl u_a (
        .clk(clk), .rst(rst), .stallreq_for_load(load), .div_req(div_req),
        .div_ready(div_ready), .perf_clr(perf_clr), .stall(a_stall),
        .div_start(a_start), .div_abort(a_abort), .div_err(a_err),
        .stall_cycles(a_cnt)
    );

    stall_ctrl #(.DIV_TIMEOUT(4), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .stallreq_for_load(load), .div_req(div_req),
        .div_ready(div_ready), .perf_clr(perf_clr), .stall(b_stall),
        .div_start(b_start), .div_abort(b_abort), .div_err(b_err),
        .stall_cycles(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; div_req = 1'b1; div_ready = 1'b0; perf_clr = 1'b0;
        tick(); tick();
        // Reset forces outputs low even with div_req high.
        #1;
        chk("rst_stall", 32'(a_stall), 32'h0);
        chk("rst_start", 32'(a_start), 32'h0);
        rst = 1'b0; div_req = 1'b0;
        #1;
        chk("rst_cnt_a", a_cnt, 32'h0);
        chk("rst_err_a", 32'(a_err), 32'h0);
        chk("rst_cnt_b", 32'(b_cnt), 32'h0);
        tick();

        // Load-use for one cycle.
        load = 1'b1; #1;
        chk("ld_stall", 32'(a_stall), 32'h07);
        chk("ld_start", 32'(a_start), 32'h0);
        tick();
        load = 1'b0; perf_clr = 1'b1; #1;
        chk("ld_release", 32'(a_stall), 32'h0);
        chk("ld_cnt", a_cnt, 32'd1);
        tick();
        perf_clr = 1'b0;

        // Divide: ready five cycles after start.
        div_req = 1'b1; #1;
        chk("dv_clr", a_cnt, 32'd0);
        chk("dv_start0", 32'(a_start), 32'h1);
        chk("dv_stall0", 32'(a_stall), 32'h0f);
        tick();
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk($sformatf("dv_stall%0d", i), 32'(a_stall), 32'h0f);
            chk($sformatf("dv_start%0d", i), 32'(a_start), 32'h0);
            tick();
        end
        div_ready = 1'b1; #1;
        chk("dv_rel_stall", 32'(a_stall), 32'h0);
        chk("dv_rel_abort", 32'(a_abort), 32'h0);
        tick();
        div_req = 1'b0; div_ready = 1'b0; #1;
        chk("dv_idle_stall", 32'(a_stall), 32'h0);
        chk("dv_cnt", a_cnt, 32'd5);
        tick();

        // Divide and load-use together; load held through BUSY.
        div_req = 1'b1; load = 1'b1; #1;
        chk("pr_stall0", 32'(a_stall), 32'h0f);
        chk("pr_start0", 32'(a_start), 32'h1);
        tick();
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk($sformatf("pr_stall%0d", i), 32'(a_stall), 32'h0f);
            chk($sformatf("pr_start%0d", i), 32'(a_start), 32'h0);
            tick();
        end
        div_ready = 1'b1; load = 1'b0; #1;
        chk("pr_rel", 32'(a_stall), 32'h0);
        tick();
        div_req = 1'b0; div_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Timeout on B (DIV_TIMEOUT=4).
        div_req = 1'b1; #1;
        chk("to_start", 32'(b_start), 32'h1);
        chk("to_stall0", 32'(b_stall), 32'h0f);
        tick();
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk($sformatf("to_stall%0d", i), 32'(b_stall), 32'h0f);
            chk($sformatf("to_abort%0d", i), 32'(b_abort), 32'h0);
            tick();
        end
        #1;
        chk("to_stall4", 32'(b_stall), 32'h0);
        chk("to_abort4", 32'(b_abort), 32'h1);
        chk("to_err4", 32'(b_err), 32'h0);
        tick();
        div_req = 1'b0; #1;
        chk("to_err5", 32'(b_err), 32'h1);
        chk("to_abort5", 32'(b_abort), 32'h0);
        chk("to_a_busy", 32'(a_stall), 32'h0f);
        tick();

        // New divide on B; error stays sticky. Reset in its second BUSY cycle.
        div_req = 1'b1; #1;
        chk("rm_start", 32'(b_start), 32'h1);
        chk("rm_err_sticky", 32'(b_err), 32'h1);
        tick(); tick();
        rst = 1'b1; #1;
        chk("rm_stall_a", 32'(a_stall), 32'h0);
        chk("rm_stall_b", 32'(b_stall), 32'h0);
        chk("rm_start_b", 32'(b_start), 32'h0);
        chk("rm_abort_b", 32'(b_abort), 32'h0);
        tick();
        rst = 1'b0; div_req = 1'b0; #1;
        chk("rm_idle_b", 32'(b_stall), 32'h0);
        chk("rm_err_b", 32'(b_err), 32'h0);
        chk("rm_cnt_b", 32'(b_cnt), 32'h0);
        chk("rm_cnt_a", a_cnt, 32'h0);
        tick();

        // Ready arrives in the timeout cycle: ready wins.
        div_req = 1'b1;
        tick(); tick(); tick(); tick();
        div_ready = 1'b1; #1;
        chk("rt_stall", 32'(b_stall), 32'h0);
        chk("rt_abort", 32'(b_abort), 32'h0);
        tick();
        div_req = 1'b0; div_ready = 1'b0; #1;
        chk("rt_err", 32'(b_err), 32'h0);
        chk("rt_cnt_b", 32'(b_cnt), 32'd4);

        // Twenty load stalls: B saturates at 15.
        load = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk($sformatf("sat_stall%0d", i), 32'(b_stall), 32'h07);
            chk($sformatf("sat_cnt%0d", i), 32'(b_cnt), (4 + i > 15) ? 32'd15 : 32'(4 + i));
            tick();
        end
        perf_clr = 1'b1; #1;
        chk("sat_hold", 32'(b_cnt), 32'd15);
        chk("cnt_a24", a_cnt, 32'd24);
        tick();
        perf_clr = 1'b0; load = 1'b0; #1;
        chk("clr_b", 32'(b_cnt), 32'd0);
        chk("clr_a", a_cnt, 32'd0);
        tick();
        #1;
        chk("clr_b_hold", 32'(b_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
